// File: rtl/phase2_pkg.sv
// Shared encodings for the Phase II control path: opcodes, ALU controls, FSM states and
// instruction field positions.
package phase2_pkg;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpAdd   = 4'h1;
  localparam logic [3:0] OpSub   = 4'h2;
  localparam logic [3:0] OpAnd   = 4'h3;
  localparam logic [3:0] OpOr    = 4'h4;
  localparam logic [3:0] OpXor   = 4'h5;
  localparam logic [3:0] OpSlt   = 4'h6;
  localparam logic [3:0] OpSll   = 4'h7;
  localparam logic [3:0] OpLoad  = 4'h8;
  localparam logic [3:0] OpStore = 4'h9;
  localparam logic [3:0] OpJmp   = 4'hA;
  localparam logic [3:0] OpBz    = 4'hB;
  localparam logic [3:0] OpHalt  = 4'hF;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSlt = 3'd5,
    AluSll = 3'd6
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    ClsNop,
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsJmp,
    ClsBz,
    ClsHalt
  } instr_cls_e;

  typedef enum logic [2:0] {
    StIdle,
    StF0,
    StF1,
    StDec,
    StEx,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam int unsigned OpMsb  = 31;
  localparam int unsigned OpLsb  = 28;
  localparam int unsigned RdMsb  = 27;
  localparam int unsigned RdLsb  = 23;
  localparam int unsigned RsMsb  = 22;
  localparam int unsigned RsLsb  = 18;
  localparam int unsigned RtMsb  = 17;
  localparam int unsigned RtLsb  = 13;
  localparam int unsigned ImmMsb = 10;
  localparam int unsigned ImmLsb = 0;

  function automatic logic [3:0] ir_op(logic [31:0] ir);
    return ir[OpMsb:OpLsb];
  endfunction

  function automatic logic [4:0] ir_rd(logic [31:0] ir);
    return ir[RdMsb:RdLsb];
  endfunction

  function automatic logic [4:0] ir_rs(logic [31:0] ir);
    return ir[RsMsb:RsLsb];
  endfunction

  function automatic logic [4:0] ir_rt(logic [31:0] ir);
    return ir[RtMsb:RtLsb];
  endfunction

  function automatic logic [10:0] ir_imm(logic [31:0] ir);
    return ir[ImmMsb:ImmLsb];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: ALU operation, instruction class and illegal-opcode flag.
module ctrl_decode
  import phase2_pkg::*;
(
  input  logic [3:0] opcode,
  output alu_ctrl_e  alu_ctrl,
  output instr_cls_e cls,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = AluAdd;
    cls      = ClsNop;
    illegal  = 1'b0;
    case (opcode)
      OpNop:   cls = ClsNop;
      OpAdd:   begin cls = ClsAlu; alu_ctrl = AluAdd; end
      OpSub:   begin cls = ClsAlu; alu_ctrl = AluSub; end
      OpAnd:   begin cls = ClsAlu; alu_ctrl = AluAnd; end
      OpOr:    begin cls = ClsAlu; alu_ctrl = AluOr;  end
      OpXor:   begin cls = ClsAlu; alu_ctrl = AluXor; end
      OpSlt:   begin cls = ClsAlu; alu_ctrl = AluSlt; end
      OpSll:   begin cls = ClsAlu; alu_ctrl = AluSll; end
      OpLoad:  cls = ClsLoad;
      OpStore: cls = ClsStore;
      OpJmp:   cls = ClsJmp;
      // Branch compares rs and rt by subtracting and watching the zero flag.
      OpBz:    begin cls = ClsBz; alu_ctrl = AluSub; end
      OpHalt:  cls = ClsHalt;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/phase2_sequencer.sv
// Multicycle control FSM: fetches two 16-bit words per instruction, then drives register file,
// ALU and SRAM control lines as Moore decodes of state and IR.
module phase2_sequencer
  import phase2_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mem_rdata,
  input  logic        alu_zero,
  output logic [10:0] mem_addr,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  output logic [4:0]  rf_wa,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic [2:0]  alu_ctrl,
  output logic [10:0] pc,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic [10:0] pc_q;
  logic        illegal_q;

  alu_ctrl_e   dec_alu_ctrl;
  instr_cls_e  dec_cls;
  logic        dec_illegal;

  logic [4:0]  rd, rs, rt;
  logic [10:0] imm;
  logic        take_jump;
  logic        unused_ir;

  assign rd  = ir_rd(ir_q);
  assign rs  = ir_rs(ir_q);
  assign rt  = ir_rt(ir_q);
  assign imm = ir_imm(ir_q);
  assign unused_ir = ^ir_q[12:11];

  ctrl_decode u_ctrl_decode (
    .opcode   (ir_op(ir_q)),
    .alu_ctrl (dec_alu_ctrl),
    .cls      (dec_cls),
    .illegal  (dec_illegal)
  );

  assign take_jump = (state_q == StEx) &&
                     ((dec_cls == ClsJmp) || ((dec_cls == ClsBz) && alu_zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == StF1) ir_q[31:16] <= mem_rdata;
      if (state_q == StDec) begin
        ir_q[15:0] <= mem_rdata;
        pc_q       <= pc_q + 11'd2;
      end
      // Taken branches and jumps override the increment already applied in DEC.
      if (take_jump) pc_q <= {imm[10:1], 1'b0};
      if ((state_q == StEx) && dec_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_addr = '0;
    mem_oe_n = 1'b1;
    mem_we_n = 1'b1;
    rf_ra1   = '0;
    rf_ra2   = '0;
    rf_wa    = '0;
    rf_we    = 1'b0;
    rf_wsel  = 1'b0;
    alu_ctrl = AluAdd;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StF0;
      end
      StF0: begin
        mem_addr = pc_q;
        mem_oe_n = 1'b0;
        state_d  = StF1;
      end
      StF1: begin
        mem_addr = pc_q + 11'd1;
        mem_oe_n = 1'b0;
        state_d  = StDec;
      end
      StDec: begin
        state_d = StEx;
      end
      StEx: begin
        rf_ra1   = rs;
        rf_ra2   = rt;
        alu_ctrl = dec_alu_ctrl;
        if (dec_cls == ClsAlu) begin
          rf_wa = rd;
          rf_we = (rd != 5'd0);
        end
        case (dec_cls)
          ClsLoad, ClsStore: state_d = StMem;
          ClsHalt:           state_d = StHalt;
          default:           state_d = StF0;
        endcase
      end
      StMem: begin
        mem_addr = imm;
        if (dec_cls == ClsLoad) begin
          mem_oe_n = 1'b0;
          state_d  = StWb;
        end else begin
          mem_we_n = 1'b0;
          rf_ra2   = rt;
          state_d  = StF0;
        end
      end
      StWb: begin
        rf_wa   = rd;
        rf_we   = (rd != 5'd0);
        rf_wsel = 1'b1;
        state_d = StF0;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pc      = pc_q;
  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_phase2_sequencer.sv
// Scoreboard bench for phase2_sequencer with SRAM, register file and ALU models around it.
module tb_phase2_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] mem_rdata = '0;
  logic        alu_zero;
  logic [10:0] mem_addr;
  logic        mem_oe_n, mem_we_n;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic        rf_we, rf_wsel;
  logic [2:0]  alu_ctrl;
  logic [10:0] pc;
  logic        halted, illegal;

  phase2_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_rdata (mem_rdata),
    .alu_zero  (alu_zero),
    .mem_addr  (mem_addr),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .rf_ra1    (rf_ra1),
    .rf_ra2    (rf_ra2),
    .rf_wa     (rf_wa),
    .rf_we     (rf_we),
    .rf_wsel   (rf_wsel),
    .alu_ctrl  (alu_ctrl),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_rf;
    logic [10:0] addr;
    logic [31:0] data;
  } ld_t;

  typedef struct {
    logic        is_mem;
    logic [10:0] addr;
    logic [31:0] data;
    int          rel;
  } ev_t;

  logic [15:0] mem [2048];
  logic [31:0] rf  [32];
  ld_t         ld_q[$];
  ev_t         exp_q[$];
  int          cyc = 0;
  int          base = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] alu_out;

  localparam logic [63:0] RstVec = {18'd0, 11'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                                    3'd0, 11'd0, 1'b0, 1'b0};

  function automatic logic [31:0] alu_fn(logic [2:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {31'd0, $signed(a) < $signed(b)};
      3'd6:    return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_ctrl, rf[rf_ra1], rf[rf_ra2]);
  assign alu_zero = (alu_out == 32'd0);

  // Single writer for the memory and register models; bench preloads drain one per cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_oe_n) mem_rdata <= mem[mem_addr];
    if (!mem_we_n) mem[mem_addr] <= rf[rf_ra2][15:0];
    if (rf_we) rf[rf_wa] <= rf_wsel ? {16'd0, mem_rdata} : alu_out;
    if (ld_q.size() != 0) begin
      if (ld_q[0].is_rf) rf[ld_q[0].addr[4:0]] <= ld_q[0].data;
      else mem[ld_q[0].addr] <= ld_q[0].data[15:0];
      void'(ld_q.pop_front());
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {18'd0, mem_addr, mem_oe_n, mem_we_n, rf_ra1, rf_ra2, rf_wa, rf_we, rf_wsel,
            alu_ctrl, pc, halted, illegal};
  endfunction

  function automatic logic [31:0] enc(logic [3:0] op, logic [4:0] rd, logic [4:0] rs,
                                      logic [4:0] rt, logic [10:0] imm);
    return {op, rd, rs, rt, 2'b00, imm};
  endfunction

  task automatic put_mem(input logic [10:0] a, input logic [15:0] d);
    ld_q.push_back({1'b0, a, 16'd0, d});
  endtask

  task automatic put_reg(input logic [4:0] r, input logic [31:0] d);
    ld_q.push_back({1'b1, {6'd0, r}, d});
  endtask

  task automatic put_instr(input logic [10:0] a, input logic [31:0] w);
    put_mem(a, w[31:16]);
    put_mem(a + 11'd1, w[15:0]);
  endtask

  task automatic flush_loads();
    for (int i = 0; i < 200 && ld_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic expect_ev(input logic is_mem, input logic [10:0] a, input logic [31:0] d,
                           input int rel);
    ev_t e;
    e.is_mem = is_mem;
    e.addr   = a;
    e.data   = d;
    e.rel    = rel;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic is_mem, input logic [10:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_write: mem=%0d addr=0x%0h data=0x%0h at cycle %0d", is_mem, a,
               d, cyc - base);
    end else begin
      e = exp_q.pop_front();
      chk("write_event", {19'd0, is_mem, a, d}, {19'd0, e.is_mem, e.addr, e.data});
      chk("write_cycle", 64'(cyc - base), 64'(e.rel));
    end
  endtask

  // Monitor: every register or SRAM write the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_oe_n && !mem_we_n) chk("oe_we_both_low", 64'd1, 64'd0);
      if (!mem_we_n) check_ev(1'b1, mem_addr, {16'd0, rf[rf_ra2][15:0]});
      if (rf_we) check_ev(1'b0, {6'd0, rf_wa}, rf_wsel ? {16'd0, mem_rdata} : alu_out);
    end
  end

  task automatic wait_rel(input int n);
    for (int i = 0; i < 1000 && (cyc - base) < n; i++) @(negedge clk);
  endtask

  logic bad;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    put_reg(5'd1, 32'd5);
    put_reg(5'd2, 32'd7);
    put_reg(5'd8, 32'h0000_F000);
    put_mem(11'h100, 16'hBEEF);
    put_instr(11'h000, enc(4'h1, 5'd3, 5'd1, 5'd2, 11'h000));
    put_instr(11'h002, enc(4'h8, 5'd4, 5'd0, 5'd0, 11'h100));
    put_instr(11'h004, enc(4'h9, 5'd0, 5'd0, 5'd4, 11'h101));
    put_instr(11'h006, enc(4'h9, 5'd0, 5'd0, 5'd8, 11'h000));
    put_instr(11'h008, enc(4'h1, 5'd0, 5'd1, 5'd2, 11'h000));
    put_instr(11'h00A, enc(4'hB, 5'd0, 5'd1, 5'd1, 11'h040));
    put_instr(11'h040, enc(4'hB, 5'd0, 5'd1, 5'd2, 11'h010));
    put_instr(11'h042, enc(4'hC, 5'd9, 5'd1, 5'd2, 11'h000));
    put_instr(11'h044, enc(4'h2, 5'd5, 5'd2, 5'd1, 11'h000));
    put_instr(11'h046, enc(4'h7, 5'd6, 5'd1, 5'd2, 11'h000));
    put_instr(11'h048, enc(4'hA, 5'd0, 5'd0, 5'd0, 11'h7FF));
    put_instr(11'h7FE, enc(4'h5, 5'd7, 5'd1, 5'd2, 11'h000));
    flush_loads();
    @(negedge clk);
    chk("reset_outputs", outs(), RstVec);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_without_start", {53'd0, mem_oe_n, mem_addr}, {53'd0, 1'b1, 11'd0});

    expect_ev(1'b0, 11'd3, 32'd12, 4);
    expect_ev(1'b0, 11'd4, 32'h0000_BEEF, 10);
    expect_ev(1'b1, 11'h101, 32'h0000_BEEF, 15);
    expect_ev(1'b1, 11'h000, 32'h0000_F000, 20);
    expect_ev(1'b0, 11'd5, 32'd2, 40);
    expect_ev(1'b0, 11'd6, 32'd640, 44);
    expect_ev(1'b0, 11'd7, 32'd2, 52);

    start = 1'b1;
    base  = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("f0_fetch", {51'd0, mem_addr, mem_oe_n, mem_we_n}, {51'd0, 11'd0, 1'b0, 1'b1});
    wait_rel(4);
    chk("add_ex_ctrl", {50'd0, alu_ctrl, pc}, {50'd0, 3'd0, 11'd2});
    wait_rel(5);
    chk("next_fetch_addr", {53'd0, mem_addr}, 64'd2);
    wait_rel(10);
    chk("load_wb", {58'd0, rf_wsel, rf_wa}, {58'd0, 1'b1, 5'd4});
    wait_rel(29);
    chk("bz_taken_pc", {53'd0, pc}, 64'h40);
    wait_rel(33);
    chk("bz_not_taken_pc", {52'd0, illegal, pc}, {52'd0, 1'b0, 11'h42});
    wait_rel(37);
    chk("illegal_set", {63'd0, illegal}, 64'd1);
    wait_rel(49);
    chk("jmp_lsb_forced", {42'd0, pc, mem_addr}, {42'd0, 11'h7FE, 11'h7FE});
    wait_rel(52);
    chk("pc_wrap", {53'd0, pc}, 64'd0);
    wait_rel(57);
    chk("halted", {63'd0, halted}, 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = ~start;
      @(negedge clk);
      if (!mem_oe_n || !mem_we_n || !halted) bad = 1'b1;
    end
    start = 1'b0;
    chk("halt_quiet", {63'd0, bad}, 64'd0);
    chk("illegal_sticky", {63'd0, illegal}, 64'd1);
    chk("scoreboard_drained_a", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    rst_n = 1'b0;
    put_instr(11'h000, enc(4'h9, 5'd0, 5'd0, 5'd4, 11'h120));
    put_instr(11'h002, enc(4'hF, 5'd0, 5'd0, 5'd0, 11'h000));
    put_mem(11'h120, 16'h1234);
    flush_loads();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    base  = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_rel(4);
    @(posedge clk);
    #2;
    chk("store_we_active", {52'd0, mem_we_n, mem_addr}, {52'd0, 1'b0, 11'h120});
    rst_n = 1'b0;
    #1;
    chk("store_abort_we", {63'd0, mem_we_n}, 64'd1);
    chk("reset_outputs_mid_store", outs(), RstVec);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!mem_oe_n || (mem_addr != 11'd0)) bad = 1'b1;
    end
    chk("idle_after_reset", {63'd0, bad}, 64'd0);
    chk("store_aborted", {48'd0, mem[11'h120]}, 64'h1234);

    expect_ev(1'b1, 11'h120, 32'h0000_BEEF, 5);
    start = 1'b1;
    base  = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
    chk("halt_latency", 64'(cyc - base), 64'd10);
    chk("scoreboard_drained_b", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
